// File: rtl/multi_digit_seconds_counter.sv
// Cascaded NUM_DIGITS x radix-BASE up/down counter with prescaled tick,
// plus a time-multiplexed 7-segment scan driver with optional leading-zero blanking.
module multi_digit_seconds_counter #(
    parameter int CLK_DIV    = 10_000_000,
    parameter int NUM_DIGITS = 4,
    parameter int BASE       = 10,
    parameter int SCAN_DIV   = 10_000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tick,
    output logic                    rollover,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0]    MAX_DIGIT = 4'(BASE - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           scan_idx;
    logic                    step;
    logic                    carry;
    logic [3:0]              cur;
    logic [4*NUM_DIGITS-1:0] count_next;
    logic [4*NUM_DIGITS-1:0] load_clamped;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   sel_next;
    logic [3:0]              scan_digit;
    logic                    scan_blank;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    assign step = en && (presc == PRE_LAST);

    // Single-cycle ripple: carry/borrow out of the top digit is the wrap flag.
    always_comb begin
        carry      = 1'b1;
        cur        = 4'd0;
        count_next = count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur = count[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (cur == MAX_DIGIT) begin
                        count_next[4*i +: 4] = 4'd0;
                    end else begin
                        count_next[4*i +: 4] = cur + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (cur == 4'd0) begin
                        count_next[4*i +: 4] = MAX_DIGIT;
                    end else begin
                        count_next[4*i +: 4] = cur - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clamped[4*i +: 4] = (load_value[4*i +: 4] > MAX_DIGIT) ?
                                     MAX_DIGIT : load_value[4*i +: 4];
        end
    end

    // Digit i>0 blanks when it and every higher digit are zero.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (count[4*i +: 4] == 4'd0);
            blank[i]   = BLANK_LZ && zero_above;
        end
    end

    always_comb begin
        scan_digit = 4'd0;
        scan_blank = 1'b0;
        sel_next   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                scan_digit  = count[4*i +: 4];
                scan_blank  = blank[i];
                sel_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            count    <= '0;
            tick     <= 1'b0;
            rollover <= 1'b0;
        end else begin
            tick     <= 1'b0;
            rollover <= 1'b0;
            if (clear) begin
                presc <= '0;
                count <= '0;
            end else begin
                if (en) begin
                    presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
                end
                if (load) begin
                    count <= load_clamped;
                end else if (step) begin
                    count    <= count_next;
                    tick     <= 1'b1;
                    rollover <= carry;
                end
            end
        end
    end

    // Scan runs free of en/clear/load; outputs follow the index one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            scan_idx  <= '0;
            digit_sel <= NUM_DIGITS'(1);
            segments  <= 7'h00;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            digit_sel <= sel_next;
            segments  <= scan_blank ? 7'h00 : seg7(scan_digit);
        end
    end
endmodule

// File: tb/tb_multi_digit_seconds_counter.sv
// Directed bench for multi_digit_seconds_counter: two instances (blanking on/off)
// share all inputs; expectations are hand-computed for CLK_DIV=4, SCAN_DIV=2, 3 digits.
module tb_multi_digit_seconds_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [11:0] load_value = 12'h000;
    logic [11:0] count, count_nb;
    logic        tick, tick_nb, rollover, rollover_nb;
    logic [6:0]  segments, segments_nb;
    logic [2:0]  digit_sel, digit_sel_nb;

    int vectors = 0;
    int miscompares = 0;

    multi_digit_seconds_counter #(
        .CLK_DIV(4), .NUM_DIGITS(3), .BASE(10), .SCAN_DIV(2), .BLANK_LZ(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_value(load_value), .count(count), .tick(tick),
        .rollover(rollover), .segments(segments), .digit_sel(digit_sel)
    );

    multi_digit_seconds_counter #(
        .CLK_DIV(4), .NUM_DIGITS(3), .BASE(10), .SCAN_DIV(2), .BLANK_LZ(1'b0)
    ) u_dut_nb (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_value(load_value), .count(count_nb), .tick(tick_nb),
        .rollover(rollover_nb), .segments(segments_nb), .digit_sel(digit_sel_nb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves prescaler at 0 with count = v and en low.
    task automatic prep(input logic [11:0] v);
        en = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        load = 1'b1;
        load_value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        cycles(2);
        vectors++;
        if ({count, tick, rollover, digit_sel, segments} !== {12'h000, 2'b00, 3'b001, 7'h00}) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h",
                     {count, tick, rollover, digit_sel, segments}, {12'h000, 2'b00, 3'b001, 7'h00});
        end
        vectors++;
        if ({digit_sel_nb, segments_nb} !== {3'b001, 7'h00}) begin
            miscompares++;
            $display("FAIL reset_state_nb: got %h expected %h", {digit_sel_nb, segments_nb}, {3'b001, 7'h00});
        end
    endtask

    task automatic test_count_up;
        logic [13:0] exp;
        reset = 1'b0;
        en = 1'b1;
        up_dn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = {12'(k / 4), (k % 4 == 0), 1'b0};
            vectors++;
            if ({count, tick, rollover} !== exp) begin
                miscompares++;
                $display("FAIL count_up cycle %0d: got %h expected %h", k, {count, tick, rollover}, exp);
            end
        end
    endtask

    task automatic test_load_rollover;
        prep(12'h999);
        en = 1'b1;
        cycles(3);
        vectors++;
        if ({count, tick, rollover} !== {12'h999, 2'b00}) begin
            miscompares++;
            $display("FAIL pre_wrap: got %h expected %h", {count, tick, rollover}, {12'h999, 2'b00});
        end
        cycles(1);
        vectors++;
        if ({count, tick, rollover} !== {12'h000, 2'b11}) begin
            miscompares++;
            $display("FAIL up_wrap: got %h expected %h", {count, tick, rollover}, {12'h000, 2'b11});
        end
        cycles(1);
        vectors++;
        if ({count, tick, rollover} !== {12'h000, 2'b00}) begin
            miscompares++;
            $display("FAIL wrap_pulse_width: got %h expected %h", {count, tick, rollover}, {12'h000, 2'b00});
        end
        en = 1'b0;
        load = 1'b1;
        load_value = 12'hFA3;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if ({count, tick, rollover} !== {12'h993, 2'b00}) begin
            miscompares++;
            $display("FAIL load_clamp: got %h expected %h", {count, tick, rollover}, {12'h993, 2'b00});
        end
        prep(12'h099);
        en = 1'b1;
        cycles(4);
        vectors++;
        if ({count, tick, rollover} !== {12'h100, 2'b10}) begin
            miscompares++;
            $display("FAIL ripple_carry: got %h expected %h", {count, tick, rollover}, {12'h100, 2'b10});
        end
    endtask

    task automatic test_count_down;
        prep(12'h000);
        up_dn = 1'b0;
        en = 1'b1;
        cycles(3);
        vectors++;
        if ({count, tick, rollover} !== {12'h000, 2'b00}) begin
            miscompares++;
            $display("FAIL pre_down_wrap: got %h expected %h", {count, tick, rollover}, {12'h000, 2'b00});
        end
        cycles(1);
        vectors++;
        if ({count, tick, rollover} !== {12'h999, 2'b11}) begin
            miscompares++;
            $display("FAIL down_wrap: got %h expected %h", {count, tick, rollover}, {12'h999, 2'b11});
        end
        // up_dn only matters on the step cycle: flip it mid-prescale.
        prep(12'h010);
        up_dn = 1'b1;
        en = 1'b1;
        cycles(2);
        up_dn = 1'b0;
        cycles(2);
        vectors++;
        if ({count, tick, rollover} !== {12'h009, 2'b10}) begin
            miscompares++;
            $display("FAIL down_borrow: got %h expected %h", {count, tick, rollover}, {12'h009, 2'b10});
        end
    endtask

    task automatic test_pause;
        prep(12'h005);
        up_dn = 1'b1;
        en = 1'b1;
        cycles(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({count, tick, rollover} !== {12'h005, 2'b00}) begin
                miscompares++;
                $display("FAIL paused cycle %0d: got %h expected %h", k, {count, tick, rollover}, {12'h005, 2'b00});
            end
        end
        en = 1'b1;
        cycles(1);
        vectors++;
        if ({count, tick, rollover} !== {12'h005, 2'b00}) begin
            miscompares++;
            $display("FAIL resume_early: got %h expected %h", {count, tick, rollover}, {12'h005, 2'b00});
        end
        cycles(1);
        vectors++;
        if ({count, tick, rollover} !== {12'h006, 2'b10}) begin
            miscompares++;
            $display("FAIL resume_step: got %h expected %h", {count, tick, rollover}, {12'h006, 2'b10});
        end
        clear = 1'b1;
        load = 1'b1;
        load_value = 12'h444;
        @(negedge clk);
        clear = 1'b0;
        load = 1'b0;
        vectors++;
        if ({count, tick, rollover} !== {12'h000, 2'b00}) begin
            miscompares++;
            $display("FAIL clear_over_load: got %h expected %h", {count, tick, rollover}, {12'h000, 2'b00});
        end
        // clear on a step cycle: no pulse, prescaler restarts from 0
        prep(12'h005);
        en = 1'b1;
        cycles(3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        vectors++;
        if ({count, tick, rollover} !== {12'h000, 2'b00}) begin
            miscompares++;
            $display("FAIL clear_on_step: got %h expected %h", {count, tick, rollover}, {12'h000, 2'b00});
        end
        cycles(4);
        vectors++;
        if ({count, tick, rollover} !== {12'h001, 2'b10}) begin
            miscompares++;
            $display("FAIL after_clear_step: got %h expected %h", {count, tick, rollover}, {12'h001, 2'b10});
        end
    endtask

    task automatic test_load_on_step;
        prep(12'h005);
        up_dn = 1'b1;
        en = 1'b1;
        cycles(3);
        load = 1'b1;
        load_value = 12'h123;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if ({count, tick, rollover} !== {12'h123, 2'b00}) begin
            miscompares++;
            $display("FAIL load_on_step: got %h expected %h", {count, tick, rollover}, {12'h123, 2'b00});
        end
        cycles(3);
        vectors++;
        if ({count, tick, rollover} !== {12'h123, 2'b00}) begin
            miscompares++;
            $display("FAIL load_presc_pre: got %h expected %h", {count, tick, rollover}, {12'h123, 2'b00});
        end
        cycles(1);
        vectors++;
        if ({count, tick, rollover} !== {12'h124, 2'b10}) begin
            miscompares++;
            $display("FAIL load_presc_step: got %h expected %h", {count, tick, rollover}, {12'h124, 2'b10});
        end
    endtask

    task automatic test_scan;
        logic [11:0] pats [2];
        logic [6:0]  exp_b [2][3];
        logic [6:0]  exp_n [2][3];
        logic [2:0]  exp_sel;
        int guard;
        pats[0] = 12'h007;
        exp_b[0][0] = 7'h07; exp_b[0][1] = 7'h00; exp_b[0][2] = 7'h00;
        exp_n[0][0] = 7'h07; exp_n[0][1] = 7'h3F; exp_n[0][2] = 7'h3F;
        pats[1] = 12'h050;
        exp_b[1][0] = 7'h3F; exp_b[1][1] = 7'h6D; exp_b[1][2] = 7'h00;
        exp_n[1][0] = 7'h3F; exp_n[1][1] = 7'h6D; exp_n[1][2] = 7'h3F;
        for (int p = 0; p < 2; p++) begin
            prep(pats[p]);
            guard = 0;
            while (digit_sel !== 3'b100 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            while (digit_sel !== 3'b001 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            vectors++;
            if (guard >= 20 && digit_sel !== 3'b001) begin
                miscompares++;
                $display("FAIL scan_sync pattern %0d: got digit_sel %b expected 001 within bound", p, digit_sel);
            end
            for (int k = 0; k < 6; k++) begin
                exp_sel = 3'b001 << (k / 2);
                vectors++;
                if ({digit_sel, segments} !== {exp_sel, exp_b[p][k/2]}) begin
                    miscompares++;
                    $display("FAIL scan_blank p%0d step %0d: got %h expected %h",
                             p, k, {digit_sel, segments}, {exp_sel, exp_b[p][k/2]});
                end
                vectors++;
                if ({digit_sel_nb, segments_nb} !== {exp_sel, exp_n[p][k/2]}) begin
                    miscompares++;
                    $display("FAIL scan_noblank p%0d step %0d: got %h expected %h",
                             p, k, {digit_sel_nb, segments_nb}, {exp_sel, exp_n[p][k/2]});
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_async_reset;
        prep(12'h123);
        up_dn = 1'b1;
        en = 1'b1;
        cycles(2);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({count, tick, rollover, digit_sel, segments} !== {12'h000, 2'b00, 3'b001, 7'h00}) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h",
                     {count, tick, rollover, digit_sel, segments}, {12'h000, 2'b00, 3'b001, 7'h00});
        end
        vectors++;
        if ({count_nb, digit_sel_nb, segments_nb} !== {12'h000, 3'b001, 7'h00}) begin
            miscompares++;
            $display("FAIL async_reset_nb: got %h expected %h",
                     {count_nb, digit_sel_nb, segments_nb}, {12'h000, 3'b001, 7'h00});
        end
        cycles(2);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({count, tick, rollover} !== {12'((k == 4) ? 1 : 0), (k == 4), 1'b0}) begin
                miscompares++;
                $display("FAIL post_reset cycle %0d: got %h expected %h",
                         k, {count, tick, rollover}, {12'((k == 4) ? 1 : 0), (k == 4), 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_rollover();
        test_count_down();
        test_pause();
        test_load_on_step();
        test_scan();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
